// File: rtl/led_strip_tx.sv
// led_strip_tx: WS2812-style single-wire LED strip transmitter.
// On start, fetches one RGB color per LED by index, reorders it to GRB and
// shifts it out MSB-first as pulse-width-coded bits. Each frame ends with a
// low latch period followed by a one-cycle done pulse.
// Optional build macro LED_STRIP_TX_BRIGHTNESS_EN adds a global brightness
// input brilho that scales every channel when the color is loaded.
module led_strip_tx #(
  parameter int NUM_LEDS     = 8,
  parameter int T_BIT        = 62,
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int LATCH_CYCLES = 3000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] cor_in,
`ifdef LED_STRIP_TX_BRIGHTNESS_EN
  input  logic [7:0]  brilho,
`endif
  output logic [7:0]  led_idx,
  output logic        busy,
  output logic        done,
  output logic        dout
);

  localparam int PH_W = $clog2(T_BIT);
  localparam int LT_W = (LATCH_CYCLES > 0) ? $clog2(LATCH_CYCLES + 1) : 1;

  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(T_BIT - 1);
  localparam logic [PH_W-1:0] HI_ZERO  = PH_W'(T0H);
  localparam logic [PH_W-1:0] HI_ONE   = PH_W'(T1H);
  localparam logic [LT_W-1:0] LAT_LAST = LT_W'(LATCH_CYCLES);
  localparam logic [7:0]      IDX_LAST = 8'(NUM_LEDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

  state_t            state, next;
  logic [23:0]       shreg;
  logic [4:0]        bit_cnt;
  logic [PH_W-1:0]   phase;
  logic [LT_W-1:0]   lat_cnt;
  logic [23:0]       load_word;
  logic [PH_W-1:0]   hi_time;
  logic              dout_next;
  logic              bit_end;

  function automatic logic [23:0] to_grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

`ifdef LED_STRIP_TX_BRIGHTNESS_EN
  // c' = (c * (b + 1)) >> 8; b = 255 leaves c unchanged, b = 0 blanks it.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] prod;
    prod = {9'd0, c} * ({8'd0, b} + 17'd1);
    return prod[15:8];
  endfunction

  assign load_word = to_grb({scale(cor_in[23:16], brilho),
                             scale(cor_in[15:8],  brilho),
                             scale(cor_in[7:0],   brilho)});
`else
  assign load_word = to_grb(cor_in);
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  // Next-state logic and the combinational value of the serial line.
  always_comb begin
    next      = state;
    bit_end   = (phase == PH_LAST);
    hi_time   = shreg[23] ? HI_ONE : HI_ZERO;
    dout_next = 1'b0;
    case (state)
      IDLE:  if (start && !done) next = LOAD;
      LOAD:  next = SEND;
      SEND: begin
        dout_next = (phase < hi_time);
        if (bit_end && bit_cnt == 5'd0)
          next = (led_idx == IDX_LAST) ? LATCH : LOAD;
      end
      LATCH: if (lat_cnt == LAT_LAST) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Registered control outputs; done blocks a start in its own cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      dout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      led_idx <= 8'd0;
    end else begin
      dout <= dout_next;
      busy <= (next != IDLE);
      done <= (state == LATCH) && (next == IDLE);
      if (next == IDLE)
        led_idx <= 8'd0;
      else if (state == SEND && next == LOAD)
        led_idx <= led_idx + 8'd1;
    end
  end

  // Shift register, bit/phase counters and latch counter.
  always_ff @(posedge clock) begin
    case (state)
      LOAD: begin
        shreg   <= load_word;
        bit_cnt <= 5'd23;
        phase   <= '0;
      end
      SEND: begin
        lat_cnt <= '0;
        if (bit_end) begin
          phase   <= '0;
          shreg   <= {shreg[22:0], 1'b0};
          bit_cnt <= bit_cnt - 5'd1;
        end else begin
          phase <= phase + 1'b1;
        end
      end
      LATCH: lat_cnt <= lat_cnt + 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/led_strip_tx.md
Name: led_strip_tx

Overview:
- Serial transmitter for a WS2812-style single-wire LED strip; the output end of the color path fed by `led_color_fader` (`cor_out`) and other color sources.
- On `start`, fetches one 24-bit RGB color per LED by index, reorders it to GRB and shifts it out MSB-first as pulse-width-coded bits.
- Closes each frame with a low latch period.

Parameters:
NUM_LEDS, 8, number of LEDs per frame (1..256)
T_BIT, 62, clock cycles per data bit (1.24 us at 50 MHz)
T0H, 20, high cycles for a '0' bit (400 ns)
T1H, 40, high cycles for a '1' bit (800 ns)
LATCH_CYCLES, 3000, low cycles of end-of-frame latch (60 us)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle frame request; ignored while busy
cor_in  input  24  RGB color of LED led_idx (R=[23:16], G=[15:8], B=[7:0])
led_idx  output  8  index of LED whose color is requested
busy  output  1  high from the edge after accepted start until frame done
done  output  1  one-cycle pulse at end of latch period
dout  output  1  registered serial data line to the strip

Behaviour:
- Reset (synchronous, active-high) values: dout=0, busy=0, done=0, led_idx=0, state=IDLE.
- Reset has priority over start in the same cycle.
- Reset mid-frame aborts immediately: dout is low on the following edge, and there is no latch period or done pulse.
- IDLE: dout=0.
  - start=1 → LOAD on the next edge; busy=1, led_idx=0.
  - start=0 → remain in IDLE.
- LOAD (exactly 1 cycle, dout=0):
  - cor_in is sampled at the end of this cycle.
  - led_idx has been stable for the whole LOAD cycle, so a combinational lookup is allowed.
  - Shift register ← {cor_in[15:8], cor_in[23:16], cor_in[7:0]} (GRB).
  - Bit counter ← 23, phase counter ← 0.
  - Next state → SEND.
- SEND:
  - Phase counter runs 0..T_BIT-1.
  - dout=1 while phase < (current bit ? T1H : T0H), otherwise 0. dout is registered, so the line lags the counter by one cycle, applied uniformly.
  - At phase=T_BIT-1: shift left 1, decrement bit counter, reset phase.
  - After bit 0 of the current LED:
    - led_idx < NUM_LEDS-1 → led_idx+1, go to LOAD.
    - else → LATCH.
  - The LOAD cycle adds one extra low cycle between LEDs (20 ns at 50 MHz, within strip tolerance). This gap is required behaviour.
- LATCH: dout=0 for exactly LATCH_CYCLES cycles, then done=1 for one cycle, busy=0, led_idx=0, → IDLE.
- Frame duration from the start edge to the done pulse: NUM_LEDS*(1+24*T_BIT)+LATCH_CYCLES+1 cycles.
- start while busy=1 (including the done cycle) is ignored and not queued.
- cor_in changes outside the LOAD sample point have no effect.
- Widths:
  - Phase counter is clog2(T_BIT) bits.
  - Latch counter is clog2(LATCH_CYCLES+1) bits.
  - led_idx is 8 bits and never exceeds NUM_LEDS-1, so no wrap-around.
- Parameter constraint: T0H < T1H < T_BIT. Other values are unsupported.

Optional Feature:
- Macro: LED_STRIP_TX_BRIGHTNESS_EN.
- Defined:
  - Extra input port brilho[7:0] (global brightness).
  - In LOAD, each channel is scaled to c' = (c*(brilho+1))>>8 before GRB packing.
  - The scale is a 9x8 multiply per channel, registered into the shift register in the same LOAD cycle.
  - brilho=255 gives unscaled output; brilho=0 gives c>>8 = 0 for all c.
  - brilho is sampled only in LOAD.
- Not defined: port absent; colors are transmitted unscaled; timing is identical.

Test Plan:
- Reset release, no start for 100 cycles → dout=0, busy=0, done=0, led_idx=0 throughout.
- NUM_LEDS=1, cor_in=24'hFF0000, start pulse → dout pattern is 8 '0' bits (high 20 cycles), then 8 '1' bits (high 40 cycles), then 8 '0' bits. Each bit period is 62 cycles. Then 3000 low cycles and done high exactly 1 cycle, 1+24*62+3000+1=4490 cycles after the start edge.
- NUM_LEDS=3, external lookup {0:24'h00FF00, 1:24'h0000FF, 2:24'h123456} → decoded GRB stream equals FF0000, 0000FF, 341256 in that order. led_idx is 0,1,2 during the respective LOAD cycles, and there is one low gap cycle per LOAD.
- start re-pulsed at cycles 10 and 2000 of a frame, and on the done cycle → ignored, with exactly one done per accepted start. A start one cycle after done begins a new frame.
- reset asserted mid-bit on LED 1 of 3 → next edge: dout=0, busy=0, led_idx=0, no done. A subsequent start produces a full, correct frame.
- With LED_STRIP_TX_BRIGHTNESS_EN, cor_in=24'hFF8040, brilho=8'h7F → transmitted GRB = 40,7F,20. With brilho=8'hFF → 80,FF,40.
